i2c_target_regs: RTL and testbench

Parametrised I2C target (slave) with an internal byte-wide register bank: the next generation of the team's single-address, 4-bit I2C slave. Oversamples SCL/SDA on the system clock, detects START/STOP/repeated START, and supports addressed write and read with register-pointer auto-increment. Sits between the board-level open-drain pads and on-chip logic, which reads the bank through a host port.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_target_regs_if.sv | 9 +
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_target_regs.sv | 156 +++++++++++++++
 tb/tb_i2c_target_regs.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C blocks: FSM state encoding, bus constants and
// the pointer-width helper.
package i2c_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_PTR    = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_RD     = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_ADDR   = S_ADDR,
        ST_PTR    = S_PTR,
        ST_WR     = S_WR,
        ST_RD     = S_RD,
        ST_IGNORE = S_IGNORE
    } i2c_state_t;

    localparam int   RW_BIT   = 0;
    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// Pad-side I2C signals of the target: sampled SCL/SDA levels and the SDA pull-down enable.
interface i2c_target_regs_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges and START/STOP
// conditions as single-cycle pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    // Flops reset to the idle-bus level so leaving reset never looks like an edge on a quiet bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl & ~scl_d;
    assign scl_fall  = ~scl &  scl_d;
    assign start_det =  scl & scl_d & sda_d & ~sda;
    assign stop_det  =  scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank: addressed writes through a register
// pointer with auto-increment, reads with prefetch, host-side read port.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter int               ADDR_W      = 7,
    parameter logic [ADDR_W-1:0] TARGET_ADDR = 7'h4C,
    parameter int               NUM_REGS    = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [7:0]       RESET_VAL   = 8'h00,
    localparam int              PTR_W       = ptr_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    i2c_target_regs_if.slave  bus,
    input  logic [PTR_W-1:0]  host_addr,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [PTR_W-1:0]  wr_index,
    output logic              busy,
    output logic              stop_pulse
);

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t       state;
    logic [3:0]       bit_cnt;
    logic             in_ack;
    logic             ack_bit;
    logic [7:0]       shreg;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic             ptr_ok;
    logic             sda_oe_r;
    logic [7:0]       regs [NUM_REGS];

    assign ptr_next   = ptr + 1'b1;
    assign ptr_ok     = ({1'b0, shreg} < 9'(NUM_REGS));
    assign host_rdata = regs[host_addr];
    assign bus.sda_oe = sda_oe_r;

    // Bus events are ignored while we pull SDA low; otherwise START/STOP override bit handling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            in_ack     <= 1'b0;
            ack_bit    <= NACK_LVL;
            shreg      <= 8'h00;
            ptr        <= '0;
            sda_oe_r   <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_index   <= '0;
            busy       <= 1'b0;
            stop_pulse <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_strobe  <= 1'b0;
            stop_pulse <= 1'b0;
            if (stop_det && !sda_oe_r) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                stop_pulse <= 1'b1;
                in_ack     <= 1'b0;
                bit_cnt    <= 4'd0;
            end else if (start_det && !sda_oe_r) begin
                state   <= ST_ADDR;
                in_ack  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WR: begin
                        if (scl_rise && !in_ack) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && !in_ack && bit_cnt == 4'd8) begin
                            if (state == ST_ADDR && shreg[7:1] != TARGET_ADDR) begin
                                state <= ST_IGNORE;
                            end else if (state == ST_PTR && !ptr_ok) begin
                                state <= ST_IGNORE;
                            end else begin
                                sda_oe_r <= 1'b1;
                                in_ack   <= 1'b1;
                                if (state == ST_ADDR) busy <= 1'b1;
                            end
                        end else if (scl_fall && in_ack) begin
                            in_ack   <= 1'b0;
                            bit_cnt  <= 4'd0;
                            sda_oe_r <= 1'b0;
                            if (state == ST_ADDR) begin
                                if (shreg[RW_BIT]) begin
                                    // Prefetch the first read byte and put its MSB on the bus right away
                                    state    <= ST_RD;
                                    shreg    <= regs[ptr];
                                    sda_oe_r <= ~regs[ptr][7];
                                end else begin
                                    state <= ST_PTR;
                                end
                            end else if (state == ST_PTR) begin
                                ptr   <= shreg[PTR_W-1:0];
                                state <= ST_WR;
                            end else begin
                                regs[ptr] <= shreg;
                                wr_strobe <= 1'b1;
                                wr_index  <= ptr;
                                ptr       <= ptr_next;
                            end
                        end
                    end
                    ST_RD: begin
                        if (scl_fall && !in_ack) begin
                            if (bit_cnt == 4'd7) begin
                                sda_oe_r <= 1'b0;
                                in_ack   <= 1'b1;
                            end else begin
                                shreg    <= {shreg[6:0], 1'b0};
                                sda_oe_r <= ~shreg[6];
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end else if (scl_rise && in_ack) begin
                            ack_bit <= sda;
                        end else if (scl_fall && in_ack) begin
                            in_ack  <= 1'b0;
                            bit_cnt <= 4'd0;
                            if (ack_bit == ACK_LVL) begin
                                ptr      <= ptr_next;
                                shreg    <= regs[ptr_next];
                                sda_oe_r <= ~regs[ptr_next][7];
                            end else begin
                                state    <= ST_IGNORE;
                                sda_oe_r <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: open-drain bus model, bit-level controller tasks and a
// register-bank/pointer reference model driven by directed and random transactions.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int NREG = 16;
    localparam int Q    = 6;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_index;
    logic       busy;
    logic       stop_pulse;

    int total = 0;
    int bad   = 0;
    int stops = 0;
    int strobe_q[$];
    int exp_strobes[$];
    logic [7:0] wq[$];
    logic [7:0] mreg [NREG];
    int mptr = 0;

    always #5 clk = ~clk;

    i2c_target_regs_if bus();
    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_target_regs #(
        .ADDR_W(7), .TARGET_ADDR(7'h4C), .NUM_REGS(NREG), .SYNC_STAGES(2), .RESET_VAL(8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_index   (wr_index),
        .busy       (busy),
        .stop_pulse (stop_pulse)
    );

    always @(posedge clk) begin
        if (wr_strobe === 1'b1) strobe_q.push_back(int'(wr_index));
        if (stop_pulse === 1'b1) stops++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    wait_q();
        scl_drv = 1'b1; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        b = bus.sda_in;
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(input logic give_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~give_ack);
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NREG; i++) begin
            host_addr = 4'(i);
            @(negedge clk);
            check_output($sformatf("%s reg%0d", tag, i), 32'(host_rdata), 32'(mreg[i]));
        end
    endtask

    // Write transaction: address byte, pointer byte, then every byte in wq
    task automatic apply_stimulus_write(input string tag, input logic [7:0] abyte, input logic [7:0] pbyte);
        logic ack;
        bit   live;
        int   s0;
        s0 = stops;
        strobe_q.delete();
        exp_strobes.delete();
        i2c_start();
        send_byte(abyte, ack);
        live = (abyte[7:1] == 7'h4C) && (abyte[0] == 1'b0);
        check_output({tag, " addr ack"}, 32'(ack), 32'(live));
        check_output({tag, " busy"}, 32'(busy), 32'(live));
        send_byte(pbyte, ack);
        check_output({tag, " ptr ack"}, 32'(ack), 32'(live && pbyte < NREG));
        if (live && pbyte < NREG) mptr = pbyte;
        else live = 0;
        foreach (wq[i]) begin
            send_byte(wq[i], ack);
            check_output($sformatf("%s data%0d ack", tag, i), 32'(ack), 32'(live));
            if (live) begin
                mreg[mptr] = wq[i];
                exp_strobes.push_back(mptr);
                mptr = (mptr + 1) % NREG;
            end
        end
        i2c_stop();
        check_output({tag, " stop count"}, 32'(stops), 32'(s0 + 1));
        check_output({tag, " busy after stop"}, 32'(busy), 32'd0);
        check_output({tag, " strobe count"}, 32'(strobe_q.size()), 32'(exp_strobes.size()));
        foreach (exp_strobes[i])
            if (i < strobe_q.size())
                check_output($sformatf("%s strobe%0d index", tag, i), 32'(strobe_q[i]), 32'(exp_strobes[i]));
    endtask

    // Read transaction, optionally setting the pointer first and using a repeated START
    task automatic apply_stimulus_read(input string tag, input bit set_ptr, input logic [7:0] pbyte, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            send_byte(8'h98, ack);
            check_output({tag, " addr-w ack"}, 32'(ack), 32'd1);
            send_byte(pbyte, ack);
            check_output({tag, " ptr ack"}, 32'(ack), 32'd1);
            mptr = pbyte;
            i2c_start();
        end
        send_byte(8'h99, ack);
        check_output({tag, " addr-r ack"}, 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n - 1, d);
            check_output($sformatf("%s byte%0d", tag, i), 32'(d), 32'(mreg[mptr]));
            if (i != n - 1) mptr = (mptr + 1) % NREG;
        end
        repeat (4) @(negedge clk);
        check_output({tag, " sda released"}, 32'(bus.sda_oe), 32'd0);
        i2c_stop();
    endtask

    initial begin
        logic b;
        for (int i = 0; i < NREG; i++) mreg[i] = 8'h00;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset sda_oe", 32'(bus.sda_oe), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset wr_strobe", 32'(wr_strobe), 32'd0);
        check_output("reset stop_pulse", 32'(stop_pulse), 32'd0);
        check_bank("reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        wq = '{8'hA5, 8'h5A};
        apply_stimulus_write("burst", 8'h98, 8'h03);
        check_bank("burst");

        apply_stimulus_read("read", 1'b1, 8'h03, 2);

        wq = '{8'hEE};
        apply_stimulus_write("wrongaddr", 8'h90, 8'h05);
        check_bank("wrongaddr");
        wq = '{8'h42};
        apply_stimulus_write("after-wrong", 8'h98, 8'h06);

        wq = '{8'h11, 8'h22, 8'h33};
        apply_stimulus_write("wrap", 8'h98, 8'h0F);
        check_bank("wrap");

        wq = '{8'h77, 8'h88};
        apply_stimulus_write("oor", 8'h98, 8'h10);
        apply_stimulus_read("oor ptr kept", 1'b0, 8'h00, 1);

        for (int t = 0; t < 6; t++) begin
            wq.delete();
            for (int k = 0; k < int'($urandom_range(3, 1)); k++) wq.push_back(8'($urandom));
            apply_stimulus_write($sformatf("rnd%0d", t),
                                 ($urandom_range(4) == 0) ? 8'h90 : 8'h98,
                                 8'($urandom_range(17)));
            apply_stimulus_read($sformatf("rndrd%0d", t), 1'b0, 8'h00, int'($urandom_range(3, 1)));
        end
        check_bank("random");

        wq = '{8'hA5};
        apply_stimulus_write("prep", 8'h98, 8'h03);
        i2c_start();
        send_byte(8'h98, b);
        send_byte(8'h03, b);
        i2c_start();
        send_byte(8'h99, b);
        check_output("midreset addr ack", 32'(b), 32'd1);
        for (int i = 0; i < 4; i++) recv_bit(b);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; repeat (2) @(negedge clk);
        check_output("midreset oe before", 32'(bus.sda_oe), 32'd1);
        reset = 1'b0;
        #1;
        check_output("midreset oe now", 32'(bus.sda_oe), 32'd0);
        for (int i = 0; i < NREG; i++) mreg[i] = 8'h00;
        mptr = 0;
        repeat (3) @(negedge clk);
        check_output("midreset busy", 32'(busy), 32'd0);
        check_bank("midreset");
        scl_drv = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_q();
        i2c_stop();
        wq = '{8'hC3, 8'h3C};
        apply_stimulus_write("postreset", 8'h98, 8'h08);
        check_bank("postreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
